// File: rtl/fht_seq_ctrl.sv
// fht_seq_ctrl - address/enable sequencer for the in-place 4-bank FHT datapath.
//
// Runs S = A_BIT+2 stages of T = 2^A_BIT + WR_LAT + 1 cycles each. Every
// stage streams D = 2^A_BIT read address pairs, the matching write address
// pairs WR_LAT cycles later, and coefficient ROM addresses one cycle after
// the reads. The bank set written alternates between stages (ping-pong).
//
// Parameters:
//   A_BIT   bank address width (bank depth D = 2^A_BIT)
//   WR_LAT  read-to-write pipeline latency in cycles (1..7)
//
// Optional feature macro:
//   FHT_HOLD_EN  adds the iHOLD stall input. A held cycle freezes the whole
//                sequence and masks oWE_A/oWE_B/oDONE for that cycle.
//
// Ports:
//   iCLK_2        core clock
//   iRESET        asynchronous active-low reset
//   iSTART        start request, taken only while oRDY=1
//   iHOLD         stall (FHT_HOLD_EN builds only)
//   oRDY          idle flag
//   oDONE         one-cycle pulse in the last busy cycle
//   oSTAGE        current stage number
//   oST_ZERO      busy in stage 0
//   oST_LAST      busy in the last stage
//   oSECTOR       sector index of the current read address
//   oADDR_RD_A/B  read addresses (B is the mirror partner)
//   oADDR_WR_A/B  write addresses
//   oADDR_COEF    coefficient ROM address
//   oWE_A/B       write enables for bank sets A/B
//   oSOURCE_DATA  bank set read in this stage (0 = A)

module fht_seq_ctrl #(
  parameter int A_BIT  = 8,
  parameter int WR_LAT = 2
) (
  input  logic                       iCLK_2,
  input  logic                       iRESET,
  input  logic                       iSTART,
`ifdef FHT_HOLD_EN
  input  logic                       iHOLD,
`endif
  output logic                       oRDY,
  output logic                       oDONE,
  output logic [$clog2(A_BIT+2)-1:0] oSTAGE,
  output logic                       oST_ZERO,
  output logic                       oST_LAST,
  output logic [A_BIT-1:0]           oSECTOR,
  output logic [A_BIT-1:0]           oADDR_RD_A,
  output logic [A_BIT-1:0]           oADDR_RD_B,
  output logic [A_BIT-1:0]           oADDR_WR_A,
  output logic [A_BIT-1:0]           oADDR_WR_B,
  output logic [A_BIT-1:0]           oADDR_COEF,
  output logic                       oWE_A,
  output logic                       oWE_B,
  output logic                       oSOURCE_DATA
);

  localparam int D  = 1 << A_BIT;
  localparam int S  = A_BIT + 2;
  localparam int T  = D + WR_LAT + 1;
  localparam int SW = $clog2(S);
  localparam int TW = $clog2(T);
  localparam int HW = $clog2(A_BIT + 1);

  localparam logic [TW-1:0]    T_LAST  = TW'(T - 1);
  localparam logic [TW-1:0]    T_RDEND = TW'(D);
  localparam logic [TW-1:0]    T_WRBEG = TW'(WR_LAT);
  localparam logic [TW-1:0]    T_WREND = TW'(WR_LAT + D);
  localparam logic [TW-1:0]    T_ONE   = TW'(1);
  localparam logic [SW-1:0]    S_LAST  = SW'(S - 1);
  localparam logic [SW-1:0]    S_ONE   = SW'(1);
  localparam logic [HW-1:0]    SH_INIT = HW'(A_BIT);
  localparam logic [HW-1:0]    SH_ONE  = HW'(1);
  localparam logic [A_BIT-1:0] LAT_A   = A_BIT'(WR_LAT);
  localparam logic [A_BIT-1:0] A_ONE   = A_BIT'(1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t          state_q, state_n;
  logic [TW-1:0]   t_q, t_n;
  logic [SW-1:0]   stage_n;
  // sh is log2(div): the sub-block size is held as a shift amount
  logic [HW-1:0]   sh_q, sh_n;
  logic            step;
  logic            hold;
  logic            we_a_q, we_b_q, done_q;

  logic [A_BIT:0]   div_n;
  logic [A_BIT-1:0] mask_n, half_n, cnt_n, mirror_n, w_n;
  logic             in_rd, in_wr;

`ifdef FHT_HOLD_EN
  assign hold = iHOLD;
`else
  assign hold = 1'b0;
`endif

  function automatic logic [A_BIT-1:0] bit_rev(input logic [A_BIT-1:0] v);
    logic [A_BIT-1:0] r;
    for (int i = 0; i < A_BIT; i++) r[i] = v[A_BIT-1-i];
    return r;
  endfunction

  // Next sequencing state. Stage 0 and stage 1 share div = D; every later
  // stage halves it, so the last stage works on single-point sub-blocks.
  always_comb begin
    state_n = state_q;
    t_n     = t_q;
    stage_n = oSTAGE;
    sh_n    = sh_q;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          state_n = ST_RUN;
          t_n     = '0;
          stage_n = '0;
          sh_n    = SH_INIT;
          step    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          step = 1'b1;
          if (t_q == T_LAST) begin
            t_n = '0;
            if (oSTAGE == S_LAST) begin
              state_n = ST_IDLE;
              stage_n = '0;
              sh_n    = SH_INIT;
            end else begin
              stage_n = oSTAGE + S_ONE;
              sh_n    = (oSTAGE == '0) ? sh_q : sh_q - SH_ONE;
            end
          end else begin
            t_n = t_q + T_ONE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Address arithmetic for the upcoming cycle; everything wraps modulo 2^A_BIT.
  // The mirror partner of r inside a sub-block is (div - r) mod div = (-r) & mask.
  always_comb begin
    div_n    = {{A_BIT{1'b0}}, 1'b1} << sh_n;
    mask_n   = div_n[A_BIT-1:0] - A_ONE;
    half_n   = div_n[A_BIT:1];
    cnt_n    = t_n[A_BIT-1:0];
    mirror_n = (cnt_n & ~mask_n) | ((~(cnt_n & mask_n) + A_ONE) & mask_n);
    w_n      = cnt_n - LAT_A;
    in_rd    = (t_n < T_RDEND);
    in_wr    = (t_n >= T_WRBEG) && (t_n < T_WREND);
  end

  // All outputs are registered from the next-state values, so each output
  // reflects the stage/time slot of the cycle it is visible in. A held cycle
  // leaves every register untouched.
  always_ff @(posedge iCLK_2 or negedge iRESET) begin
    if (!iRESET) begin
      state_q      <= ST_IDLE;
      t_q          <= '0;
      sh_q         <= SH_INIT;
      oRDY         <= 1'b1;
      done_q       <= 1'b0;
      oSTAGE       <= '0;
      oST_ZERO     <= 1'b0;
      oST_LAST     <= 1'b0;
      oSECTOR      <= '0;
      oADDR_RD_A   <= '0;
      oADDR_RD_B   <= '0;
      oADDR_WR_A   <= '0;
      oADDR_WR_B   <= '0;
      oADDR_COEF   <= '0;
      we_a_q       <= 1'b0;
      we_b_q       <= 1'b0;
      oSOURCE_DATA <= 1'b0;
    end else begin
      state_q <= state_n;
      t_q     <= t_n;
      sh_q    <= sh_n;
      oSTAGE  <= stage_n;
      if (state_n == ST_IDLE) begin
        oRDY         <= 1'b1;
        done_q       <= 1'b0;
        oST_ZERO     <= 1'b0;
        oST_LAST     <= 1'b0;
        oSECTOR      <= '0;
        oADDR_RD_A   <= '0;
        oADDR_RD_B   <= '0;
        oADDR_WR_A   <= '0;
        oADDR_WR_B   <= '0;
        oADDR_COEF   <= '0;
        we_a_q       <= 1'b0;
        we_b_q       <= 1'b0;
        oSOURCE_DATA <= 1'b0;
      end else if (step) begin
        oRDY         <= 1'b0;
        oST_ZERO     <= (stage_n == '0);
        oST_LAST     <= (stage_n == S_LAST);
        oSOURCE_DATA <= stage_n[0];
        done_q       <= (stage_n == S_LAST) && (t_n == T_LAST);
        // coefficient follows the read address by one cycle
        oADDR_COEF   <= bit_rev(oSECTOR);
        if (in_rd) begin
          oADDR_RD_A <= cnt_n;
          oADDR_RD_B <= (stage_n == '0) ? cnt_n : mirror_n;
          oSECTOR    <= cnt_n >> sh_n;
        end
        if (in_wr) begin
          oADDR_WR_A <= w_n;
          oADDR_WR_B <= ((stage_n == '0) || (stage_n == S_LAST)) ? w_n : (w_n ^ half_n);
          we_a_q     <= stage_n[0];
          we_b_q     <= ~stage_n[0];
        end else begin
          we_a_q <= 1'b0;
          we_b_q <= 1'b0;
        end
      end
    end
  end

  // A stalled cycle must not write or signal completion; the same slot is
  // replayed once the stall is released.
  assign oWE_A = we_a_q & ~hold;
  assign oWE_B = we_b_q & ~hold;
  assign oDONE = done_q & ~hold;

endmodule

// File: tb/tb_fht_seq_ctrl.sv
// tb_fht_seq_ctrl - directed self-checking bench for fht_seq_ctrl with
// A_BIT=3 (D=8, S=5) and WR_LAT=2 (T=11, 55 busy cycles per run).
// The stall scenario is compiled in when FHT_HOLD_EN is defined.

module tb_fht_seq_ctrl;

  localparam int A_BIT  = 3;
  localparam int WR_LAT = 2;

  logic       iCLK_2 = 1'b0;
  logic       iRESET;
  logic       iSTART;
`ifdef FHT_HOLD_EN
  logic       iHOLD;
`endif
  logic       oRDY;
  logic       oDONE;
  logic [2:0] oSTAGE;
  logic       oST_ZERO;
  logic       oST_LAST;
  logic [2:0] oSECTOR;
  logic [2:0] oADDR_RD_A;
  logic [2:0] oADDR_RD_B;
  logic [2:0] oADDR_WR_A;
  logic [2:0] oADDR_WR_B;
  logic [2:0] oADDR_COEF;
  logic       oWE_A;
  logic       oWE_B;
  logic       oSOURCE_DATA;

  int checks = 0;
  int errors = 0;

  // hand-computed stage tables for D=8
  int rdb2[8]  = '{0, 3, 2, 1, 4, 7, 6, 5};
  int wrb2[8]  = '{2, 3, 0, 1, 6, 7, 4, 5};
  int coef2[8] = '{0, 0, 0, 0, 4, 4, 4, 4};
  int coef3[8] = '{0, 0, 4, 4, 2, 2, 6, 6};
  int coef4[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int sh_of[5] = '{3, 3, 2, 1, 0};

  always #5 iCLK_2 = ~iCLK_2;

  fht_seq_ctrl #(.A_BIT(A_BIT), .WR_LAT(WR_LAT)) dut (
    .iCLK_2      (iCLK_2),
    .iRESET      (iRESET),
    .iSTART      (iSTART),
`ifdef FHT_HOLD_EN
    .iHOLD       (iHOLD),
`endif
    .oRDY        (oRDY),
    .oDONE       (oDONE),
    .oSTAGE      (oSTAGE),
    .oST_ZERO    (oST_ZERO),
    .oST_LAST    (oST_LAST),
    .oSECTOR     (oSECTOR),
    .oADDR_RD_A  (oADDR_RD_A),
    .oADDR_RD_B  (oADDR_RD_B),
    .oADDR_WR_A  (oADDR_WR_A),
    .oADDR_WR_B  (oADDR_WR_B),
    .oADDR_COEF  (oADDR_COEF),
    .oWE_A       (oWE_A),
    .oWE_B       (oWE_B),
    .oSOURCE_DATA(oSOURCE_DATA)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // drive iSTART for one active edge, then sample point is 1 time unit later
  task automatic applyStimulus(input logic start_v);
    iSTART = start_v;
    @(posedge iCLK_2);
    #1;
    iSTART = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " rdy"},     32'(oRDY), 1);
    checkOutput({tag, " done"},    32'(oDONE), 0);
    checkOutput({tag, " stage"},   32'(oSTAGE), 0);
    checkOutput({tag, " st_zero"}, 32'(oST_ZERO), 0);
    checkOutput({tag, " st_last"}, 32'(oST_LAST), 0);
    checkOutput({tag, " sector"},  32'(oSECTOR), 0);
    checkOutput({tag, " rd_a"},    32'(oADDR_RD_A), 0);
    checkOutput({tag, " rd_b"},    32'(oADDR_RD_B), 0);
    checkOutput({tag, " wr_a"},    32'(oADDR_WR_A), 0);
    checkOutput({tag, " wr_b"},    32'(oADDR_WR_B), 0);
    checkOutput({tag, " coef"},    32'(oADDR_COEF), 0);
    checkOutput({tag, " we_a"},    32'(oWE_A), 0);
    checkOutput({tag, " we_b"},    32'(oWE_B), 0);
    checkOutput({tag, " source"},  32'(oSOURCE_DATA), 0);
  endtask

  initial begin
    int s, t, c, w, rdb, wrb, cf;
    int ncyc;
    bit win;

    iRESET = 1'b1;
    iSTART = 1'b0;
`ifdef FHT_HOLD_EN
    iHOLD  = 1'b0;
`endif
    #1 iRESET = 1'b0;
    #2;
    $display("[TB] reset state");
    checkIdle("reset");
    @(posedge iCLK_2);
    #1 iRESET = 1'b1;
    applyStimulus(1'b0);
    checkIdle("idle");

    // full run: every busy cycle checked, stray iSTART at cycle 20
    $display("[TB] full run");
    applyStimulus(1'b1);
    for (int n = 1; n <= 55; n++) begin
      s = (n - 1) / 11;
      t = (n - 1) % 11;
      c = (t < 8) ? t : 7;
      case (s)
        1:       rdb = (8 - c) % 8;
        2:       rdb = rdb2[c];
        default: rdb = c;
      endcase
      win = (t >= 2) && (t <= 9);
      checkOutput($sformatf("rdy s%0d t%0d", s, t),     32'(oRDY), 0);
      checkOutput($sformatf("stage s%0d t%0d", s, t),   32'(oSTAGE), s);
      checkOutput($sformatf("st_zero s%0d t%0d", s, t), 32'(oST_ZERO), (s == 0) ? 1 : 0);
      checkOutput($sformatf("st_last s%0d t%0d", s, t), 32'(oST_LAST), (s == 4) ? 1 : 0);
      checkOutput($sformatf("source s%0d t%0d", s, t),  32'(oSOURCE_DATA), s % 2);
      checkOutput($sformatf("done s%0d t%0d", s, t),    32'(oDONE), (n == 55) ? 1 : 0);
      checkOutput($sformatf("rd_a s%0d t%0d", s, t),    32'(oADDR_RD_A), c);
      checkOutput($sformatf("rd_b s%0d t%0d", s, t),    32'(oADDR_RD_B), rdb);
      checkOutput($sformatf("sector s%0d t%0d", s, t),  32'(oSECTOR), c >> sh_of[s]);
      checkOutput($sformatf("we_a s%0d t%0d", s, t),    32'(oWE_A), (win && (s % 2 == 1)) ? 1 : 0);
      checkOutput($sformatf("we_b s%0d t%0d", s, t),    32'(oWE_B), (win && (s % 2 == 0)) ? 1 : 0);
      if (win) begin
        w = t - 2;
        case (s)
          1:       wrb = w ^ 4;
          2:       wrb = wrb2[w];
          3:       wrb = w ^ 1;
          default: wrb = w;
        endcase
        checkOutput($sformatf("wr_a s%0d t%0d", s, t), 32'(oADDR_WR_A), w);
        checkOutput($sformatf("wr_b s%0d t%0d", s, t), 32'(oADDR_WR_B), wrb);
      end
      if (t >= 1 && t <= 8) begin
        case (s)
          2:       cf = coef2[t - 1];
          3:       cf = coef3[t - 1];
          4:       cf = coef4[t - 1];
          default: cf = 0;
        endcase
        checkOutput($sformatf("coef s%0d t%0d", s, t), 32'(oADDR_COEF), cf);
      end
      if (n < 55) applyStimulus(n == 20);
    end

    // iSTART coinciding with oDONE must be ignored
    applyStimulus(1'b1);
    checkIdle("after_done");
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("still_idle rdy", 32'(oRDY), 1);
    checkOutput("still_idle stage", 32'(oSTAGE), 0);

    // asynchronous reset in the middle of stage 3's write window
    $display("[TB] mid-run reset");
    applyStimulus(1'b1);
    repeat (37) applyStimulus(1'b0);
    checkOutput("pre_reset stage", 32'(oSTAGE), 3);
    checkOutput("pre_reset we_a", 32'(oWE_A), 1);
    iRESET = 1'b0;
    #2;
    checkIdle("mid_reset");
    applyStimulus(1'b0);
    iRESET = 1'b1;
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("post_reset rdy c%0d", k),  32'(oRDY), 1);
      checkOutput($sformatf("post_reset we_a c%0d", k), 32'(oWE_A), 0);
      checkOutput($sformatf("post_reset we_b c%0d", k), 32'(oWE_B), 0);
    end

`ifdef FHT_HOLD_EN
    // 5-cycle stall at stage 1, t=4 (inside the write window)
    $display("[TB] hold run");
    applyStimulus(1'b1);
    repeat (15) applyStimulus(1'b0);
    checkOutput("pre_hold we_a", 32'(oWE_A), 1);
    checkOutput("pre_hold wr_a", 32'(oADDR_WR_A), 2);
    iHOLD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("hold we_a c%0d", k),  32'(oWE_A), 0);
      checkOutput($sformatf("hold we_b c%0d", k),  32'(oWE_B), 0);
      checkOutput($sformatf("hold rd_a c%0d", k),  32'(oADDR_RD_A), 4);
      checkOutput($sformatf("hold wr_a c%0d", k),  32'(oADDR_WR_A), 2);
      checkOutput($sformatf("hold stage c%0d", k), 32'(oSTAGE), 1);
      @(posedge iCLK_2);
      #1;
    end
    iHOLD = 1'b0;
    #1;
    checkOutput("release we_a", 32'(oWE_A), 1);
    checkOutput("release wr_a", 32'(oADDR_WR_A), 2);
    checkOutput("release rd_a", 32'(oADDR_RD_A), 4);
    ncyc = 21;
    applyStimulus(1'b0);
    ncyc++;
    checkOutput("resume wr_a", 32'(oADDR_WR_A), 3);
    checkOutput("resume rd_a", 32'(oADDR_RD_A), 5);
    while (oDONE !== 1'b1 && ncyc < 100) begin
      applyStimulus(1'b0);
      ncyc++;
    end
    checkOutput("hold done_latency", 32'(ncyc), 60);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
